// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared definitions for the instruction fetch stage: fetch
//             state encoding, Wishbone byte-select constant and the default
//             boot address.
//  Contents : fetch_state_t, WB_SEL_WORD, BOOT_ADDRESS_DEFAULT,
//             halfword_align()
//  Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

    // Fetch sequencer states
    //   IDLE    : no bus cycle open, waiting to issue a request
    //   REQ     : request outstanding, waiting for ack
    //   HOLD    : fetched word parked, waiting for FIFO space / stall release
    //   DISCARD : request outstanding across a redirect, data will be dropped
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    localparam logic [3:0]  WB_SEL_WORD          = 4'hF;
    localparam logic [31:0] BOOT_ADDRESS_DEFAULT = 32'h0000_1000;

    // Instructions are at least halfword aligned, so bit 0 of any PC is
    // meaningless and forced to zero.
    function automatic logic [31:0] halfword_align(input logic [31:0] addr);
        return addr & ~32'h1;
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/cpu_fetch_align.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_fetch_align
//  Purpose  : Realigns the 32-bit fetched word stream when the fetch PC is
//             halfword (not word) aligned. Keeps the trailing halfword of the
//             previous bus word and splices it ahead of the next one.
//  Ports    : clk, rst_n             clock / async active-low reset
//             redirect               PC redirect this cycle (clears buffer)
//             redirect_misalign      bit 1 of the redirect target
//             consume                ack data is accepted this cycle
//             ack_data[31:0]         raw bus read data
//             word[31:0]             realigned word for the FIFO
//             suppress               this ack only primes the half buffer
//  Revision : 1.0  initial release
// ============================================================================
module cpu_fetch_align (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic        redirect_misalign,
    input  logic        consume,
    input  logic [31:0] ack_data,
    output logic [31:0] word,
    output logic        suppress
);

    logic [15:0] half;
    logic        half_v;
    logic        misalign;

    // The first word after a misaligned redirect carries only one useful
    // halfword (the low one), so it produces no FIFO word of its own.
    always_comb begin
        suppress = !half_v && misalign;
        word     = half_v ? {half, ack_data[31:16]} : ack_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half     <= 16'h0000;
            half_v   <= 1'b0;
            misalign <= 1'b0;
        end else if (redirect) begin
            half_v   <= 1'b0;
            misalign <= redirect_misalign;
        end else if (consume) begin
            // Whenever the stream is offset by a halfword, the low half of
            // each bus word becomes the high half of the next FIFO word.
            if (suppress || half_v) begin
                half <= ack_data[15:0];
            end
            if (suppress) begin
                half_v   <= 1'b1;
                misalign <= 1'b0;
            end
        end
    end

endmodule : cpu_fetch_align
`default_nettype wire

// File: rtl/cpu_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_fetch
//  Purpose  : Instruction fetch stage. Masters a read-only Wishbone bus,
//             fetches sequential words, realigns halfword-aligned redirect
//             targets and pushes words into the instruction FIFO under its
//             full backpressure. Every redirect (including the implicit one
//             after reset) pulses newPC_p_o/flush_o with the new PC.
//  Ports    : clk_i, rst_i           clock / async active-low reset
//             stall_i                pipeline stall (no request, no write)
//             branch_i, branch_target_i  redirect pulse and target
//             full_i                 FIFO full
//             write_en_o, data_o     FIFO write strobe / word
//             newPC_p_o, PC_o, flush_o   FIFO PC reload handshake
//             wb_*                   Wishbone master (read only)
//  Options  : CPU_FETCH_BUS_ERR_EN adds wb_err_i, fetch_fault_o and
//             fault_addr_o; a bus error stops fetching until a redirect.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS = BOOT_ADDRESS_DEFAULT,
    parameter int          ADDR_WIDTH   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  branch_i,
    input  logic [31:0]           branch_target_i,
    input  logic                  full_i,
    output logic                  write_en_o,
    output logic [31:0]           data_o,
    output logic                  newPC_p_o,
    output logic [31:0]           PC_o,
    output logic                  flush_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [3:0]            wb_sel_o,
    input  logic [31:0]           wb_dat_i,
`ifdef CPU_FETCH_BUS_ERR_EN
    input  logic                  wb_err_i,
    output logic                  fetch_fault_o,
    output logic [31:0]           fault_addr_o,
`endif
    input  logic                  wb_ack_i
);

    localparam logic [ADDR_WIDTH-1:0] BOOT_PC  = ADDR_WIDTH'(halfword_align(BOOT_ADDRESS));
    localparam logic [ADDR_WIDTH-1:0] ADR_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);

    fetch_state_t          state, state_nx;
    logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_nx;
    logic [ADDR_WIDTH-1:0] adr, adr_nx;
    logic                  cyc, cyc_nx;
    logic [31:0]           hold_word, hold_word_nx;
    logic                  hold_v, hold_v_nx;
    logic                  write_en, write_en_nx;
    logic [31:0]           data, data_nx;
    logic                  newpc_p, newpc_p_nx;
    logic [31:0]           pc_out, pc_out_nx;
    logic                  boot, boot_nx;

    logic                  redirect;
    logic [31:0]           redirect_pc;
    logic                  bus_done;
    logic                  fault_block;
    logic                  align_consume;
    logic [31:0]           align_word;
    logic                  align_suppress;

    // The first edge after reset behaves as a redirect to the boot address;
    // a real branch on that same edge takes precedence.
    assign redirect    = branch_i || boot;
    assign redirect_pc = halfword_align(branch_i ? branch_target_i : BOOT_ADDRESS);

`ifdef CPU_FETCH_BUS_ERR_EN
    logic        fault, fault_nx;
    logic [31:0] fault_addr, fault_addr_nx;

    // In DISCARD an error simply terminates the abandoned cycle.
    assign bus_done    = wb_ack_i || wb_err_i;
    assign fault_block = fault;
`else
    assign bus_done    = wb_ack_i;
    assign fault_block = 1'b0;
`endif

    cpu_fetch_align u_align (
        .clk               (clk_i),
        .rst_n             (rst_i),
        .redirect          (redirect),
        .redirect_misalign (redirect_pc[1]),
        .consume           (align_consume),
        .ack_data          (wb_dat_i),
        .word              (align_word),
        .suppress          (align_suppress)
    );

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nx      = state;
        fetch_pc_nx   = fetch_pc;
        adr_nx        = adr;
        cyc_nx        = cyc;
        hold_word_nx  = hold_word;
        hold_v_nx     = hold_v;
        write_en_nx   = 1'b0;
        data_nx       = data;
        newpc_p_nx    = 1'b0;
        pc_out_nx     = pc_out;
        boot_nx       = 1'b0;
        align_consume = 1'b0;
`ifdef CPU_FETCH_BUS_ERR_EN
        fault_nx      = fault;
        fault_addr_nx = fault_addr;
`endif

        if (redirect) begin
            // Redirect wins over everything; write_en stays low so the FIFO
            // never sees a write together with its flush.
            hold_v_nx   = 1'b0;
            fetch_pc_nx = ADDR_WIDTH'(redirect_pc);
            newpc_p_nx  = 1'b1;
            pc_out_nx   = redirect_pc;
`ifdef CPU_FETCH_BUS_ERR_EN
            fault_nx    = 1'b0;
`endif
            if ((state == REQ || state == DISCARD) && !bus_done) begin
                // A Wishbone cycle cannot be withdrawn; wait it out.
                state_nx = DISCARD;
            end else begin
                state_nx = IDLE;
                cyc_nx   = 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (!stall_i && !full_i && !hold_v && !fault_block) begin
                        cyc_nx   = 1'b1;
                        adr_nx   = fetch_pc & ADR_MASK;
                        state_nx = REQ;
                    end
                end
                REQ: begin
                    if (wb_ack_i) begin
                        cyc_nx        = 1'b0;
                        fetch_pc_nx   = fetch_pc + PC_STEP;
                        align_consume = 1'b1;
                        if (align_suppress) begin
                            state_nx = IDLE;
                        end else if (!full_i && !stall_i) begin
                            write_en_nx = 1'b1;
                            data_nx     = align_word;
                            state_nx    = IDLE;
                        end else begin
                            hold_word_nx = align_word;
                            hold_v_nx    = 1'b1;
                            state_nx     = HOLD;
                        end
                    end
`ifdef CPU_FETCH_BUS_ERR_EN
                    else if (wb_err_i) begin
                        cyc_nx        = 1'b0;
                        fault_nx      = 1'b1;
                        fault_addr_nx = 32'(adr);
                        state_nx      = IDLE;
                    end
`endif
                end
                HOLD: begin
                    if (!full_i && !stall_i && !fault_block) begin
                        write_en_nx = 1'b1;
                        data_nx     = hold_word;
                        hold_v_nx   = 1'b0;
                        state_nx    = IDLE;
                    end
                end
                DISCARD: begin
                    if (bus_done) begin
                        cyc_nx   = 1'b0;
                        state_nx = IDLE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cyc_nx   = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            fetch_pc   <= BOOT_PC;
            adr        <= ADDR_WIDTH'(BOOT_ADDRESS) & ADR_MASK;
            cyc        <= 1'b0;
            hold_word  <= 32'h0;
            hold_v     <= 1'b0;
            write_en   <= 1'b0;
            data       <= 32'h0;
            newpc_p    <= 1'b0;
            pc_out     <= BOOT_ADDRESS;
            boot       <= 1'b1;
`ifdef CPU_FETCH_BUS_ERR_EN
            fault      <= 1'b0;
            fault_addr <= 32'h0;
`endif
        end else begin
            state      <= state_nx;
            fetch_pc   <= fetch_pc_nx;
            adr        <= adr_nx;
            cyc        <= cyc_nx;
            hold_word  <= hold_word_nx;
            hold_v     <= hold_v_nx;
            write_en   <= write_en_nx;
            data       <= data_nx;
            newpc_p    <= newpc_p_nx;
            pc_out     <= pc_out_nx;
            boot       <= boot_nx;
`ifdef CPU_FETCH_BUS_ERR_EN
            fault      <= fault_nx;
            fault_addr <= fault_addr_nx;
`endif
        end
    end

    assign write_en_o = write_en;
    assign data_o     = data;
    assign newPC_p_o  = newpc_p;
    assign flush_o    = newpc_p;
    assign PC_o       = pc_out;
    assign wb_adr_o   = adr;
    assign wb_cyc_o   = cyc;
    assign wb_stb_o   = cyc;
    assign wb_we_o    = 1'b0;
    assign wb_sel_o   = WB_SEL_WORD;
`ifdef CPU_FETCH_BUS_ERR_EN
    assign fetch_fault_o = fault;
    assign fault_addr_o  = fault_addr;
`endif

endmodule : cpu_fetch
`default_nettype wire

// File: tb/tb_cpu_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_fetch
//  Purpose  : Directed scoreboard bench for cpu_fetch. Stimulus pushes the
//             expected bus addresses, FIFO writes and redirect PCs into
//             queues; a monitor pops and compares whenever the DUT presents
//             a request, a write or a newPC pulse. A small Wishbone slave
//             returns queued read data after a programmable wait.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b1;
    logic        branch = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        full = 1'b0;
    logic        write_en;
    logic [31:0] data;
    logic        newpc_p;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] wb_adr;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat = 32'h0;
    logic        wb_ack = 1'b0;
`ifdef CPU_FETCH_BUS_ERR_EN
    logic        wb_err = 1'b0;
    logic        err_mode = 1'b0;
    logic        fetch_fault;
    logic [31:0] fault_addr;
`endif

    int nchk = 0;
    int nerr = 0;
    int nreqs = 0;
    int nwrites = 0;
    int ack_delay = 0;
    int junk = 0;

    logic [31:0] exp_adr_q[$];
    logic [31:0] exp_wr_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] rsp_q[$];

    cpu_fetch #(
        .BOOT_ADDRESS (32'h0000_1000),
        .ADDR_WIDTH   (32)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .stall_i         (stall),
        .branch_i        (branch),
        .branch_target_i (branch_target),
        .full_i          (full),
        .write_en_o      (write_en),
        .data_o          (data),
        .newPC_p_o       (newpc_p),
        .PC_o            (pc),
        .flush_o         (flush),
        .wb_adr_o        (wb_adr),
        .wb_cyc_o        (wb_cyc),
        .wb_stb_o        (wb_stb),
        .wb_we_o         (wb_we),
        .wb_sel_o        (wb_sel),
        .wb_dat_i        (wb_dat),
`ifdef CPU_FETCH_BUS_ERR_EN
        .wb_err_i        (wb_err),
        .fetch_fault_o   (fetch_fault),
        .fault_addr_o    (fault_addr),
`endif
        .wb_ack_i        (wb_ack)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Wishbone slave ----------------
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                wb_ack = 1'b0;
`ifdef CPU_FETCH_BUS_ERR_EN
                wb_err = 1'b0;
`endif
                cnt = 0;
            end else if (wb_ack) begin
                wb_ack = 1'b0;
`ifdef CPU_FETCH_BUS_ERR_EN
            end else if (wb_err) begin
                wb_err = 1'b0;
`endif
            end else if (wb_cyc && wb_stb) begin
                if (cnt >= ack_delay) begin
                    cnt = 0;
`ifdef CPU_FETCH_BUS_ERR_EN
                    if (err_mode) wb_err = 1'b1;
                    else begin
`endif
                    wb_ack = 1'b1;
                    if (rsp_q.size() > 0) wb_dat = rsp_q.pop_front();
                    else begin
                        wb_dat = 32'hEEEE_0000 + 32'(junk);
                        junk++;
                    end
`ifdef CPU_FETCH_BUS_ERR_EN
                    end
`endif
                end else begin
                    cnt++;
                end
            end
        end
    end

    // ---------------- Monitor / scoreboard ----------------
    initial begin
        logic prev_cyc = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (wb_stb !== wb_cyc) check("stb_tracks_cyc", {31'b0, wb_stb}, {31'b0, wb_cyc});
            if (newpc_p || flush) begin
                check("flush_with_newpc", {31'b0, flush}, {31'b0, newpc_p});
                check("no_write_on_flush", {31'b0, write_en}, 32'h0);
                if (exp_pc_q.size() == 0) check("unexpected_newpc", {31'b0, newpc_p}, 32'h0);
                else check("newpc_PC", pc, exp_pc_q.pop_front());
            end
            if (write_en) begin
                nwrites++;
                if (exp_wr_q.size() == 0) check("unexpected_write", {31'b0, write_en}, 32'h0);
                else check("write_data", data, exp_wr_q.pop_front());
            end
            if (wb_cyc && !prev_cyc) begin
                nreqs++;
                if (exp_adr_q.size() == 0) check("unexpected_request", {31'b0, wb_cyc}, 32'h0);
                else check("request_adr", wb_adr, exp_adr_q.pop_front());
            end
            prev_cyc = wb_cyc;
        end
    end

    // ---------------- Driver helpers (run at posedge + 2) ----------------
    task automatic settle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_reqs(input int k, input string name);
        int target = nreqs + k;
        int n = 0;
        while (nreqs < target && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        check({name, "_req_timeout"}, 32'(nreqs >= target), 32'h1);
    endtask

    task automatic wait_writes(input int k, input string name);
        int target = nwrites + k;
        int n = 0;
        while (nwrites < target && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        check({name, "_write_timeout"}, 32'(nwrites >= target), 32'h1);
    endtask

    task automatic do_branch(input logic [31:0] tgt, input logic [31:0] exp_pc);
        exp_pc_q.push_back(exp_pc);
        branch        = 1'b1;
        branch_target = tgt;
        @(posedge clk);
        #2;
        branch = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- Directed stimulus ----------------
    initial begin
        int base_w;
        int base_r;
        #1 rst = 1'b0;
        #11;
        check("rst_write_en", {31'b0, write_en}, 32'h0);
        check("rst_data", data, 32'h0);
        check("rst_newpc", {31'b0, newpc_p}, 32'h0);
        check("rst_flush", {31'b0, flush}, 32'h0);
        check("rst_PC", pc, 32'h0000_1000);
        check("rst_cyc", {31'b0, wb_cyc}, 32'h0);
        check("rst_adr", wb_adr, 32'h0000_1000);
        check("rst_we", {31'b0, wb_we}, 32'h0);
        check("rst_sel", {28'b0, wb_sel}, 32'hF);

        // 1: boot redirect, zero-wait fetch
        exp_pc_q.push_back(32'h0000_1000);
        exp_adr_q.push_back(32'h0000_1000);
        exp_adr_q.push_back(32'h0000_1004);
        rsp_q.push_back(32'h0102_0304);
        exp_wr_q.push_back(32'h0102_0304);
        stall = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        wait_reqs(2, "boot");
        stall = 1'b1;
        settle(6);

        // 2: halfword-aligned target (bit 0 set, must be ignored)
        exp_adr_q.push_back(32'h0000_2000);
        exp_adr_q.push_back(32'h0000_2004);
        rsp_q.push_back(32'hAAAA_BBBB);
        rsp_q.push_back(32'hCCCC_DDDD);
        exp_wr_q.push_back(32'hBBBB_CCCC);
        do_branch(32'h0000_2003, 32'h0000_2002);
        stall = 1'b0;
        wait_writes(1, "misalign");
        stall = 1'b1;
        settle(6);

        // 3: FIFO full when ack returns
        exp_adr_q.push_back(32'h0000_3000);
        exp_adr_q.push_back(32'h0000_3004);
        rsp_q.push_back(32'h1234_5678);
        exp_wr_q.push_back(32'h1234_5678);
        do_branch(32'h0000_3000, 32'h0000_3000);
        stall = 1'b0;
        wait_reqs(1, "full");
        full = 1'b1;
        base_w = nwrites;
        base_r = nreqs;
        settle(6);
        check("full_no_write", 32'(nwrites), 32'(base_w));
        check("full_no_request", 32'(nreqs), 32'(base_r));
        check("full_bus_idle", {31'b0, wb_cyc}, 32'h0);
        full = 1'b0;
        wait_writes(1, "full_release");
        wait_reqs(1, "full_next");
        stall = 1'b1;
        settle(6);

        // 4: redirect while a request is outstanding
        exp_adr_q.push_back(32'h0000_4000);
        exp_adr_q.push_back(32'h0000_5000);
        rsp_q.push_back(32'hBAD0_BAD0);
        rsp_q.push_back(32'h5555_6666);
        exp_wr_q.push_back(32'h5555_6666);
        do_branch(32'h0000_4000, 32'h0000_4000);
        ack_delay = 3;
        stall = 1'b0;
        wait_reqs(1, "discard");
        do_branch(32'h0000_5000, 32'h0000_5000);
        check("discard_holds_cyc", {31'b0, wb_cyc}, 32'h1);
        check("discard_holds_adr", wb_adr, 32'h0000_4000);
        wait_writes(1, "discard");
        stall = 1'b1;
        ack_delay = 0;
        settle(8);

        // 5: fetch PC wraps at the top of the address space
        exp_adr_q.push_back(32'hFFFF_FFFC);
        exp_adr_q.push_back(32'h0000_0000);
        rsp_q.push_back(32'h0A0B_0C0D);
        exp_wr_q.push_back(32'h0A0B_0C0D);
        do_branch(32'hFFFF_FFFC, 32'hFFFF_FFFC);
        stall = 1'b0;
        wait_reqs(2, "wrap");
        stall = 1'b1;
        settle(6);

`ifdef CPU_FETCH_BUS_ERR_EN
        // bus error stops fetching until the next redirect
        exp_adr_q.push_back(32'h0000_3000);
        do_branch(32'h0000_3000, 32'h0000_3000);
        err_mode = 1'b1;
        stall = 1'b0;
        wait_reqs(1, "buserr");
        base_r = nreqs;
        settle(6);
        check("fault_flag", {31'b0, fetch_fault}, 32'h1);
        check("fault_addr", fault_addr, 32'h0000_3000);
        check("fault_bus_idle", {31'b0, wb_cyc}, 32'h0);
        check("fault_no_request", 32'(nreqs), 32'(base_r));
        err_mode = 1'b0;
        stall = 1'b1;
`endif

        // 6: asynchronous reset in the middle of a bus cycle
        exp_adr_q.push_back(32'h0000_6000);
        do_branch(32'h0000_6000, 32'h0000_6000);
`ifdef CPU_FETCH_BUS_ERR_EN
        check("fault_cleared", {31'b0, fetch_fault}, 32'h0);
`endif
        ack_delay = 5;
        stall = 1'b0;
        wait_reqs(1, "async_rst");
        #1 rst = 1'b0;
        #1;
        check("arst_cyc", {31'b0, wb_cyc}, 32'h0);
        check("arst_adr", wb_adr, 32'h0000_1000);
        check("arst_PC", pc, 32'h0000_1000);
        check("arst_newpc", {31'b0, newpc_p}, 32'h0);
        stall = 1'b1;
        ack_delay = 0;
        exp_pc_q.push_back(32'h0000_1000);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        settle(6);

        check("pending_requests", 32'(exp_adr_q.size()), 32'h0);
        check("pending_writes", 32'(exp_wr_q.size()), 32'h0);
        check("pending_newpc", 32'(exp_pc_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule : tb_cpu_fetch
`default_nettype wire
